// File: rtl/seven_seg_pkg.sv
// Shared encodings for the multiplexed four-digit 7-segment display bus.
// Segments and anodes are active-low; segment bits 6:0 map to g..a.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

endpackage

// File: rtl/seg_decode.sv
// Combinational segment-pattern to BCD decoder; blank maps to NIB_BLANK,
// anything unrecognised maps to NIB_ERR with err_o set.
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = NIB_ERR;
    err_o    = 1'b0;
    case (seg_i)
      SEG_0:     nibble_o = 4'd0;
      SEG_1:     nibble_o = 4'd1;
      SEG_2:     nibble_o = 4'd2;
      SEG_3:     nibble_o = 4'd3;
      SEG_4:     nibble_o = 4'd4;
      SEG_5:     nibble_o = 4'd5;
      SEG_6:     nibble_o = 4'd6;
      SEG_7:     nibble_o = 4'd7;
      SEG_8:     nibble_o = 4'd8;
      SEG_9:     nibble_o = 4'd9;
      SEG_BLANK: nibble_o = NIB_BLANK;
      default: begin
        nibble_o = NIB_ERR;
        err_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples the multiplexed display bus, captures each digit once its dwell has
// settled, and publishes the reassembled four-digit BCD value per frame.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int unsigned SettleW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SettleW-1:0]  SettleMax  = SettleW'(SETTLE_CYCLES);
  localparam logic [SettleW-1:0]  SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TIMEOUT_CYCLES);

  logic [7:0]          seg_d, seg_q;
  logic [3:0]          an_d, an_q;
  logic [11:0]         prev_d, prev_q;
  logic [SettleW-1:0]  settle_d, settle_q;
  logic [TimeoutW-1:0] timeout_d, timeout_q;
  logic [15:0]         shadow_d, shadow_q;
  logic [3:0]          seen_d, seen_q;
  logic                err_acc_d, err_acc_q;
  logic [15:0]         bcd_out_d, bcd_out_q;
  logic                frame_valid_d, frame_valid_q;
  logic                frame_err_d, frame_err_q;

  logic [3:0] dec_nib;
  logic       dec_err;
  logic [1:0] dig_idx;
  logic       one_hot;
  logic       stable;
  logic       capture;
  logic       publish;

  seg_decode u_seg_decode (
    .seg_i    (seg_q[6:0]),
    .nibble_o (dec_nib),
    .err_o    (dec_err)
  );

  always_comb begin
    seg_d  = seg;
    an_d   = an;
    prev_d = {an_q, seg_q};

    dig_idx = 2'd0;
    one_hot = 1'b1;
    case (an_q)
      AN_DIG0: dig_idx = 2'd0;
      AN_DIG1: dig_idx = 2'd1;
      AN_DIG2: dig_idx = 2'd2;
      AN_DIG3: dig_idx = 2'd3;
      default: one_hot = 1'b0;
    endcase

    stable = ({an_q, seg_q} == prev_q) && one_hot;
    // Capture on the step that takes the counter to SETTLE_CYCLES, so saturation
    // guarantees a single capture per dwell.
    capture = stable && (settle_q == SettleLast);
    publish = (seen_q == 4'b1111);

    if (!stable) begin
      settle_d = '0;
    end else if (settle_q == SettleMax) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + 1'b1;
    end

    if (publish) begin
      timeout_d = '0;
    end else if (timeout_q == TimeoutMax) begin
      timeout_d = timeout_q;
    end else begin
      timeout_d = timeout_q + 1'b1;
    end

    // Clearing precedes the capture update so a same-cycle capture opens the next frame.
    shadow_d  = shadow_q;
    seen_d    = publish ? 4'b0000 : seen_q;
    err_acc_d = publish ? 1'b0 : err_acc_q;
    if (capture) begin
      shadow_d[{dig_idx, 2'b00} +: 4] = dec_nib;
      seen_d[dig_idx]                 = 1'b1;
      err_acc_d                       = err_acc_d | dec_err;
    end

    frame_valid_d = publish;
    bcd_out_d     = publish ? shadow_q : bcd_out_q;
    frame_err_d   = publish ? err_acc_q : frame_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q         <= 8'hFF;
      an_q          <= 4'hF;
      prev_q        <= 12'hFFF;
      settle_q      <= '0;
      timeout_q     <= '0;
      shadow_q      <= 16'hFFFF;
      seen_q        <= 4'b0000;
      err_acc_q     <= 1'b0;
      bcd_out_q     <= 16'hFFFF;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      an_q          <= an_d;
      prev_q        <= prev_d;
      settle_q      <= settle_d;
      timeout_q     <= timeout_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      err_acc_q     <= err_acc_d;
      bcd_out_q     <= bcd_out_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bcd_out     = bcd_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign stale       = (timeout_q == TimeoutMax);

endmodule
